// File: rtl/coriolis_ker1_subker1_buf1.sv
// Elastic first-word-fall-through buffer behind the mul1 FP multiplier.
// It keeps sticky infinity/NaN flags for every accepted FloPoCo word.
module coriolis_ker1_subker1_buf1 #(
   parameter int STREAMW = 34,
   parameter int DEPTH   = 4,
   parameter int AW      = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ivalid_in1_s0,
   input  logic [STREAMW-1:0] in1_s0,
   output logic               iready,
   output logic               ovalid,
   output logic [STREAMW-1:0] out1_s0,
   input  logic               oready,
   output logic [AW:0]        fill,
   output logic               exc_inf,
   output logic               exc_nan
);

   localparam logic [AW:0]   FILL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   FILL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   logic [STREAMW-1:0] mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic               push;
   logic               pop;
   logic [AW:0]        fill_next;
   logic [1:0]         exc_field;

   assign push      = ivalid_in1_s0 & iready;
   assign pop       = ovalid & oready;
   assign ovalid    = (fill != '0);
   assign out1_s0   = mem[rd_ptr];
   assign exc_field = in1_s0[STREAMW-1 -: 2];

   always_comb begin
      fill_next = fill;
      if (push && !pop)
         fill_next = fill + FILL_ONE;
      else if (!push && pop)
         fill_next = fill - FILL_ONE;
   end

   // Storage is never reset; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in1_s0;
   end

   // iready is a register of the next occupancy, so oready never reaches it combinationally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         fill    <= '0;
         iready  <= 1'b1;
         exc_inf <= 1'b0;
         exc_nan <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         fill   <= fill_next;
         iready <= (fill_next != FILL_FULL);
         if (push && exc_field == 2'b10)
            exc_inf <= 1'b1;
         if (push && exc_field == 2'b11)
            exc_nan <= 1'b1;
      end
   end

endmodule

// File: tb/tb_coriolis_ker1_subker1_buf1.sv
// Directed and random checks of the elastic FWFT buffer with sticky exception flags.
module tb_coriolis_ker1_subker1_buf1;

   logic        clk;
   logic        rst;
   logic        ivalid_in1_s0;
   logic [33:0] in1_s0;
   logic        iready;
   logic        ovalid;
   logic [33:0] out1_s0;
   logic        oready;
   logic [2:0]  fill;
   logic        exc_inf;
   logic        exc_nan;

   int errors = 0;
   int checks = 0;

   logic [33:0] mq[$];
   logic        m_inf;
   logic        m_nan;
   int          pushes;

   typedef struct {
      logic        iv;
      logic [33:0] d;
      logic        ordy;
      logic [2:0]  fill;
      logic        ov;
      logic        ir;
      logic [33:0] q;
      logic        inf;
      logic        nan;
   } vec_t;

   vec_t tbl[17];

   coriolis_ker1_subker1_buf1 #(.STREAMW(34), .DEPTH(4), .AW(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .ivalid_in1_s0 (ivalid_in1_s0),
      .in1_s0        (in1_s0),
      .iready        (iready),
      .ovalid        (ovalid),
      .out1_s0       (out1_s0),
      .oready        (oready),
      .fill          (fill),
      .exc_inf       (exc_inf),
      .exc_nan       (exc_nan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock against the reference queue model.
   task automatic step(input logic iv, input logic [33:0] d, input logic ordy);
      logic p, q;
      ivalid_in1_s0 = iv;
      in1_s0        = d;
      oready        = ordy;
      p = iv && (mq.size() < 4);
      q = ordy && (mq.size() > 0);
      @(posedge clk);
      #1;
      if (q) void'(mq.pop_front());
      if (p) begin
         mq.push_back(d);
         pushes++;
         if (d[33:32] == 2'b10) m_inf = 1'b1;
         if (d[33:32] == 2'b11) m_nan = 1'b1;
      end
      chk("fill", 34'(fill), 34'(mq.size()));
      chk("ovalid", 34'(ovalid), 34'(mq.size() != 0));
      chk("iready", 34'(iready), 34'(mq.size() != 4));
      chk("exc_inf", 34'(exc_inf), 34'(m_inf));
      chk("exc_nan", 34'(exc_nan), 34'(m_nan));
      if (mq.size() > 0) chk("out1_s0", out1_s0, mq[0]);
   endtask

   initial begin
      // iv, din, ordy | fill, ovalid, iready, out, inf, nan (after the edge)
      tbl[0]  = '{1'b1, 34'h1_00000001, 1'b0, 3'd1, 1'b1, 1'b1, 34'h1_00000001, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 34'h1_00000002, 1'b0, 3'd2, 1'b1, 1'b1, 34'h1_00000001, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 34'h1_00000003, 1'b0, 3'd3, 1'b1, 1'b1, 34'h1_00000001, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 34'h1_00000004, 1'b0, 3'd4, 1'b1, 1'b0, 34'h1_00000001, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 34'h1_00000005, 1'b0, 3'd4, 1'b1, 1'b0, 34'h1_00000001, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 34'h1_00000005, 1'b1, 3'd3, 1'b1, 1'b1, 34'h1_00000002, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 34'h1_00000005, 1'b1, 3'd3, 1'b1, 1'b1, 34'h1_00000003, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 34'h0_00000000, 1'b1, 3'd2, 1'b1, 1'b1, 34'h1_00000004, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 34'h0_00000000, 1'b1, 3'd1, 1'b1, 1'b1, 34'h1_00000005, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 34'h0_00000000, 1'b1, 3'd0, 1'b0, 1'b1, 34'h0_00000000, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 34'h1_3F800000, 1'b0, 3'd1, 1'b1, 1'b1, 34'h1_3F800000, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 34'h2_7F800000, 1'b0, 3'd2, 1'b1, 1'b1, 34'h1_3F800000, 1'b1, 1'b0};
      tbl[12] = '{1'b1, 34'h3_7FC00000, 1'b1, 3'd2, 1'b1, 1'b1, 34'h2_7F800000, 1'b1, 1'b1};
      tbl[13] = '{1'b1, 34'h1_40000000, 1'b1, 3'd2, 1'b1, 1'b1, 34'h3_7FC00000, 1'b1, 1'b1};
      tbl[14] = '{1'b1, 34'h0_00000000, 1'b1, 3'd2, 1'b1, 1'b1, 34'h1_40000000, 1'b1, 1'b1};
      tbl[15] = '{1'b0, 34'h0_00000000, 1'b1, 3'd1, 1'b1, 1'b1, 34'h0_00000000, 1'b1, 1'b1};
      tbl[16] = '{1'b0, 34'h0_00000000, 1'b1, 3'd0, 1'b0, 1'b1, 34'h0_00000000, 1'b1, 1'b1};

      ivalid_in1_s0 = 1'b0;
      in1_s0        = '0;
      oready        = 1'b0;
      pushes        = 0;
      rst           = 1'b1;
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_fill", 34'(fill), 34'd0);
      chk("reset_ovalid", 34'(ovalid), 34'd0);
      chk("reset_iready", 34'(iready), 34'd1);
      chk("reset_inf", 34'(exc_inf), 34'd0);
      chk("reset_nan", 34'(exc_nan), 34'd0);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;

      // Fill to full, overflow attempt, drain across wrap, then exception flags.
      for (int i = 0; i < 17; i++) begin
         ivalid_in1_s0 = tbl[i].iv;
         in1_s0        = tbl[i].d;
         oready        = tbl[i].ordy;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_fill", i), 34'(fill), 34'(tbl[i].fill));
         chk($sformatf("vec%0d_ovalid", i), 34'(ovalid), 34'(tbl[i].ov));
         chk($sformatf("vec%0d_iready", i), 34'(iready), 34'(tbl[i].ir));
         chk($sformatf("vec%0d_inf", i), 34'(exc_inf), 34'(tbl[i].inf));
         chk($sformatf("vec%0d_nan", i), 34'(exc_nan), 34'(tbl[i].nan));
         if (tbl[i].ov) chk($sformatf("vec%0d_out", i), out1_s0, tbl[i].q);
      end

      // Mid-stream asynchronous reset with fill=3.
      mq.delete();
      m_inf = 1'b1;
      m_nan = 1'b1;
      step(1'b1, 34'h1_00000011, 1'b0);
      step(1'b1, 34'h1_00000012, 1'b0);
      step(1'b1, 34'h1_00000013, 1'b0);
      ivalid_in1_s0 = 1'b0;
      #3 rst = 1'b0;
      #1;
      chk("async_rst_fill", 34'(fill), 34'd0);
      chk("async_rst_ovalid", 34'(ovalid), 34'd0);
      chk("async_rst_iready", 34'(iready), 34'd1);
      chk("async_rst_inf", 34'(exc_inf), 34'd0);
      chk("async_rst_nan", 34'(exc_nan), 34'd0);
      #1 rst = 1'b1;
      mq.delete();
      m_inf = 1'b0;
      m_nan = 1'b0;
      step(1'b1, 34'h1_43D80000, 1'b0);
      chk("post_rst_out", out1_s0, 34'h1_43D80000);
      step(1'b0, 34'h0, 1'b1);

      // Streaming pass-through with oready held high.
      for (int i = 0; i < 16; i++)
         step(1'b1, 34'h1_00000000 + 34'(i), 1'b1);
      step(1'b0, 34'h0, 1'b1);

      // Simultaneous push/pop at fill=2.
      step(1'b1, 34'h1_000000A0, 1'b0);
      step(1'b1, 34'h1_000000A1, 1'b0);
      for (int i = 0; i < 10; i++)
         step(1'b1, 34'h1_000000B0 + 34'(i), 1'b1);
      chk("simul_fill", 34'(fill), 34'd2);
      step(1'b0, 34'h0, 1'b1);
      step(1'b0, 34'h0, 1'b1);

      // Random back-pressure, 1000 accepted words.
      pushes = 0;
      for (int cyc = 0; cyc < 6000 && pushes < 1000; cyc++)
         step(1'($urandom_range(0, 1)), {2'($urandom_range(0, 3)), 32'($urandom)},
              1'($urandom_range(0, 1)));
      chk("random_pushes", 34'(pushes), 34'd1000);
      for (int i = 0; i < 5; i++)
         step(1'b0, 34'h0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/coriolis_ker1_subker1_buf1.md
# coriolis_ker1_subker1_buf1

Elastic stream buffer directly downstream of the `coriolis_ker1_subker1_mul1` FP-multiply leaf node. It absorbs back-pressure and latency mismatch before the next map node by storing up to DEPTH 34-bit FloPoCo words in a first-word-fall-through FIFO with valid/ready handshakes on both sides. It also monitors the 2-bit FloPoCo exception field of every accepted word and keeps sticky infinity/NaN flags for kernel-level debug.

## Interface
- `STREAMW`, 34, stream word width; bits [33:32] are the FloPoCo exception field, [31:0] are the IEEE-754 single payload.
- `DEPTH`, 4, FIFO capacity in words; must be a power of two, ≥2.
- `AW`, 2, address width; equals log2(DEPTH).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset); deassertion is synchronous to `clk` externally.
- `ivalid_in1_s0`  in  1  upstream word valid (producer is `mul1`'s `ovalid`).
- `in1_s0`  in  STREAMW  upstream word.
- `iready`  out  1  buffer can accept a word this cycle.
- `ovalid`  out  1  `out1_s0` holds a valid word.
- `out1_s0`  out  STREAMW  head-of-FIFO word.
- `oready`  in  1  downstream accepts a word this cycle.
- `fill`  out  AW+1  current occupancy, 0..DEPTH.
- `exc_inf`  out  1  sticky: an accepted word had exception field 2'b10.
- `exc_nan`  out  1  sticky: an accepted word had exception field 2'b11.

## Operation
- push = `ivalid_in1_s0 & iready`; pop = `ovalid & oready`.
- `iready` = (`fill` != DEPTH). It is registered from `fill`, with no combinational path from `oready`. A full buffer refuses a push even when a pop happens in the same cycle.
- `ovalid` = (`fill` != 0).
- `out1_s0` = mem[rd_ptr]. This is first-word-fall-through: the head is visible without a pop.
- Pointers `wr_ptr` and `rd_ptr` are AW bits wide and wrap modulo DEPTH with no special case.
- `fill` next value:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, with both pointers advancing
  - neither: hold
- Words pass through bit-exact. The exception field is never altered.
- Sticky flags:
  - On push, `exc_inf` |= (in[33:32]==2'b10) and `exc_nan` |= (in[33:32]==2'b11).
  - Flags are cleared only by reset.
  - Words 2'b00 (zero) and 2'b01 (normal) do not affect the flags.
- Occupancy is held in a counter with no state machine. The states are EMPTY (`fill`=0), PARTIAL, and FULL (`fill`=DEPTH), as implied by `fill`.
- Reset (`rst`=0, at any time including mid-transfer):
  - `fill`, `wr_ptr`, `rd_ptr`, `exc_inf`, `exc_nan` = 0.
  - `ovalid`=0 and `iready`=1 immediately, asynchronously.
  - Memory contents are not reset; `out1_s0` is don't-care while `ovalid`=0.
  - In-flight words are discarded.
- Illegal usage: no protection is required against upstream changing `in1_s0` while `ivalid_in1_s0`=1 and `iready`=0. The buffer samples only on push.

## Timing
- Latency: a word pushed at edge N appears on `out1_s0` with `ovalid`=1 after edge N (visible in cycle N+1), provided it is the head.
- Throughput: one word per cycle in and out, sustained when 0<`fill`<DEPTH.
- From EMPTY, a simultaneous push+pop is impossible because `ovalid`=0. The word is stored and `fill`→1.
- At FULL: `iready`=0. A pop at edge N gives `fill`=DEPTH−1 and `iready`=1 in cycle N+1. This is one bubble of upstream stall, which is acceptable.
- `fill` and the flags update on the same edge as the push/pop that caused them.
- Upstream `mul1` keeps its own result registered while its `oready` (our `iready`) is low. The buffer requires nothing further from it.

## Test plan
- **Reset/idle:**
  - Assert `rst`=0 mid-stream with `fill`=3 → in the same cycle `ovalid`=0, `iready`=1, `fill`=0, flags=0.
  - Release → the next push of 0x1_43D80000 appears on `out1_s0` one cycle later.
- **Streaming:**
  - Hold `oready`=1 and push 16 consecutive words 0x1_00000000+i → output sequence is identical and in order, one per cycle, and `fill` never exceeds 1.
- **Fill/full/wrap:**
  - Hold `oready`=0 and push 5 words (DEPTH=4) → first 4 are accepted, `iready`=0 after the 4th, `fill`=4, and the 5th is held upstream.
  - Release `oready` → 5 words drain in order across pointer wrap, with exactly one stall bubble on the input.
- **Simultaneous push/pop:**
  - With `fill`=2, push and pop together for 10 cycles → `fill` stays 2 and order is preserved.
- **Exception flags:**
  - Push 2'b01 words, then 0x2_7F800000 → `exc_inf`=1 on that edge and `exc_nan`=0.
  - Push 0x3_7FC00000 → `exc_nan`=1.
  - Both flags stay 1 through further normal traffic until reset.
- **Random back-pressure:**
  - Apply 1000 words with random `ivalid_in1_s0`/`oready` (50%) → scoreboard shows no loss, duplication or reordering.
  - `fill` always equals pushes minus pops, and `ovalid`/`iready` are consistent with `fill`.
